// File: rtl/bit_population_counter_sched_if.sv
// Requester, counter-side and result signals of the popcount scheduler.
// master = requesters/counter environment, slave = scheduler.
interface bit_population_counter_sched_if #(
  parameter int NUM_REQ         = 4,
  parameter int WIDTH           = 128,
  parameter int MAX_OUTSTANDING = 16
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  logic [NUM_REQ*WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]       req_val_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [WIDTH-1:0]         pc_data_o;
  logic                     pc_data_val_o;
  logic [CW-1:0]            pc_data_i;
  logic                     pc_data_val_i;
  logic [CW-1:0]            res_data_o;
  logic [NUM_REQ-1:0]       res_val_o;
  logic [OW-1:0]            outstanding_o;
  logic                     err_o;

  modport master (
    output req_data_i, req_val_i, pc_data_i, pc_data_val_i,
    input  req_ready_o, pc_data_o, pc_data_val_o, res_data_o, res_val_o,
           outstanding_o, err_o
  );

  modport slave (
    input  req_data_i, req_val_i, pc_data_i, pc_data_val_i,
    output req_ready_o, pc_data_o, pc_data_val_o, res_data_o, res_val_o,
           outstanding_o, err_o
  );
endinterface

// File: rtl/bit_population_counter_sched.sv
// Round-robin scheduler sharing one pipelined popcount unit; optional error flag via BPC_SCHED_ERR_CHECK_EN.
// Latency: 1 cycle grant->counter input, 1 cycle counter output->result. Backpressure: no grants while tag FIFO full.

// Generic synchronous FIFO with first-word fall-through read and registered occupancy.
// Latency: push visible on pop_dat the cycle after; count updates one cycle after push/pop.
// Backpressure: push ignored when full, pop ignored when empty; full uses current count only.
module sync_fifo #(
  parameter int DW    = 4,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   push_vld,
  input  logic [DW-1:0]          push_dat,
  input  logic                   pop_vld,
  output logic [DW-1:0]          pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push_vld & ~full;
  assign pop_ok  = pop_vld & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module bit_population_counter_sched #(
  parameter int NUM_REQ         = 4,
  parameter int WIDTH           = 128,
  parameter int MAX_OUTSTANDING = 16
) (
  input logic clk_i,
  input logic srst_i,
  bit_population_counter_sched_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CW    = $clog2(WIDTH) + 1;
  localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gidx;
  logic [PTR_W:0]     cand;
  logic [NUM_REQ-1:0] grant;
  logic               xfer;
  logic               pop_ok;
  logic [PTR_W-1:0]   tag;
  logic               fifo_full;
  logic               fifo_empty;
  logic [OW-1:0]      fifo_count;
  logic [WIDTH-1:0]   pc_dat_q;
  logic               pc_vld_q;
  logic [CW-1:0]      res_dat_q;
  logic [NUM_REQ-1:0] res_vld_q;

  // First valid requester at or above ptr (with wrap) wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    if (!srst_i && !fifo_full) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = {1'b0, ptr} + (PTR_W+1)'(i);
        if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
        if (bus.req_val_i[cand[PTR_W-1:0]] && (grant == '0)) begin
          grant[cand[PTR_W-1:0]] = 1'b1;
          gidx                   = cand[PTR_W-1:0];
        end
      end
    end
  end

  assign xfer   = |grant;
  assign pop_ok = bus.pc_data_val_i & ~fifo_empty;

  sync_fifo #(
    .DW    (PTR_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk_i),
    .srst     (srst_i),
    .push_vld (xfer),
    .push_dat (gidx),
    .pop_vld  (bus.pc_data_val_i),
    .pop_dat  (tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ptr       <= '0;
      pc_dat_q  <= '0;
      pc_vld_q  <= 1'b0;
      res_dat_q <= '0;
      res_vld_q <= '0;
    end else begin
      pc_vld_q <= xfer;
      if (xfer) begin
        pc_dat_q <= bus.req_data_i[gidx*WIDTH +: WIDTH];
        ptr      <= (gidx == PTR_W'(NUM_REQ-1)) ? '0 : gidx + PTR_W'(1);
      end
      res_vld_q <= pop_ok ? (NUM_REQ'(1) << tag) : '0;
      if (pop_ok) res_dat_q <= bus.pc_data_i;
    end
  end

`ifdef BPC_SCHED_ERR_CHECK_EN
  logic err_q;

  // A result with no tag to match, or a push into a full FIFO, means the
  // counter and the scheduler have lost step; hold the flag until reset.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      err_q <= 1'b0;
    end else if ((bus.pc_data_val_i & fifo_empty) | (xfer & fifo_full)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.req_ready_o   = grant;
  assign bus.pc_data_o     = pc_dat_q;
  assign bus.pc_data_val_o = pc_vld_q;
  assign bus.res_data_o    = res_dat_q;
  assign bus.res_val_o     = res_vld_q;
  assign bus.outstanding_o = fifo_count;
endmodule

// File: tb/tb_bit_population_counter_sched.sv
// Directed bench for the popcount scheduler with a 2-cycle counter model that can be
// bypassed so the bench drives the counter result path by hand.
module tb_bit_population_counter_sched;
  localparam int NR = 4;
  localparam int W  = 128;
  localparam int MO = 4;
`ifdef BPC_SCHED_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic [W-1:0]  words [NR];
  logic [NR-1:0] req_val = '0;
  logic          man_mode = 1'b1;
  logic          man_val = 1'b0;
  logic [7:0]    man_dat = '0;
  logic          s1v, s2v;
  logic [7:0]    s1d, s2d;
  int            n_chk = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  bit_population_counter_sched_if #(.NUM_REQ(NR), .WIDTH(W), .MAX_OUTSTANDING(MO)) bus ();

  bit_population_counter_sched #(.NUM_REQ(NR), .WIDTH(W), .MAX_OUTSTANDING(MO)) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus)
  );

  assign bus.req_data_i    = {words[3], words[2], words[1], words[0]};
  assign bus.req_val_i     = req_val;
  assign bus.pc_data_val_i = man_mode ? man_val : s2v;
  assign bus.pc_data_i     = man_mode ? man_dat : s2d;

  function automatic logic [7:0] popcnt(input logic [W-1:0] v);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < W; i++) s = s + 8'(v[i]);
    return s;
  endfunction

  // Counter model: two pipeline stages, reset together with the scheduler.
  always @(posedge clk) begin
    if (srst) begin
      s1v <= 1'b0; s2v <= 1'b0; s1d <= '0; s2d <= '0;
    end else begin
      s1v <= bus.pc_data_val_o; s1d <= popcnt(bus.pc_data_o);
      s2v <= s1v;               s2d <= s1d;
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srst = 1'b1; req_val = '0; man_val = 1'b0;
    step(); step();
    srst = 1'b0;
  endtask

  logic [7:0] cnts [NR];
  logic [3:0] fr_exp [5];

  initial begin
    foreach (words[i]) words[i] = '0;
    // Reset state
    man_mode = 1'b0;
    do_reset();
    chk("rst_ready", bus.req_ready_o, 0);
    chk("rst_pcval", bus.pc_data_val_o, 0);
    chk("rst_pcdat", bus.pc_data_o, 0);
    chk("rst_resval", bus.res_val_o, 0);
    chk("rst_resdat", bus.res_data_o, 0);
    chk("rst_outst", bus.outstanding_o, 0);
    chk("rst_err", bus.err_o, 0);

    // Single requester 1, data 0xFF -> count 8
    words[1] = 128'hFF;
    req_val = 4'b0010; #1;
    chk("t1_ready", bus.req_ready_o, 4'b0010);
    step();
    req_val = '0;
    chk("t1_pcval", bus.pc_data_val_o, 1);
    chk("t1_pcdat", bus.pc_data_o, 128'hFF);
    chk("t1_outst", bus.outstanding_o, 1);
    step(); step();
    chk("t1_early", bus.res_val_o, 0);
    step();
    chk("t1_resval", bus.res_val_o, 4'b0010);
    chk("t1_resdat", bus.res_data_o, 8);
    chk("t1_outst0", bus.outstanding_o, 0);
    step();
    chk("t1_pulse", bus.res_val_o, 0);

    // All four held valid for 8 cycles from reset
    words[0] = '1; words[1] = '0; words[2] = 128'h1; words[3] = 128'h3;
    cnts[0] = 8'd128; cnts[1] = 8'd0; cnts[2] = 8'd1; cnts[3] = 8'd2;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      req_val = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) chk("t2_ready", bus.req_ready_o, 4'b0001 << (c % 4));
      if (c >= 1 && c <= 8) begin
        chk("t2_pcval", bus.pc_data_val_o, 1);
        chk("t2_pcdat", bus.pc_data_o, words[(c-1) % 4]);
      end
      if (c >= 4) begin
        chk("t2_resval", bus.res_val_o, 4'b0001 << ((c-4) % 4));
        chk("t2_resdat", bus.res_data_o, cnts[(c-4) % 4]);
      end
      step();
    end
    chk("t2_drained", bus.outstanding_o, 0);

    // Fairness: req 0 once to move ptr to 1, then 0 and 2 held valid
    words[0] = 128'hF; words[2] = 128'hFF00;
    fr_exp[0] = 4'b0001; fr_exp[1] = 4'b0100; fr_exp[2] = 4'b0001;
    fr_exp[3] = 4'b0100; fr_exp[4] = 4'b0001;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      req_val = (c == 0) ? 4'b0001 : ((c <= 4) ? 4'b0101 : 4'b0000);
      #1;
      if (c <= 4) chk("t3_ready", bus.req_ready_o, fr_exp[c]);
      if (c >= 4) begin
        chk("t3_resval", bus.res_val_o, ((c-4) % 2 == 0) ? 4'b0001 : 4'b0100);
        chk("t3_resdat", bus.res_data_o, ((c-4) % 2 == 0) ? 8'd4 : 8'd8);
      end
      step();
    end

    // Saturation: result path stalled, four accepted, then one released
    words[0] = 128'hA5; words[1] = 128'h5A; words[2] = 128'h3C; words[3] = 128'hC3;
    man_mode = 1'b1;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req_val = 4'hF; #1;
      chk("t4_ready", bus.req_ready_o, 4'b0001 << c);
      step();
    end
    #1;
    chk("t4_full_rdy", bus.req_ready_o, 0);
    chk("t4_full_out", bus.outstanding_o, 4);
    chk("t4_stall", bus.res_val_o, 0);
    step();
    man_val = 1'b1; man_dat = 8'd77; #1;
    chk("t4_pop_rdy", bus.req_ready_o, 0);
    step();
    man_val = 1'b0; #1;
    chk("t4_resval", bus.res_val_o, 4'b0001);
    chk("t4_resdat", bus.res_data_o, 77);
    chk("t4_out3", bus.outstanding_o, 3);
    chk("t4_reopen", bus.req_ready_o, 4'b0001);
    step();
    chk("t4_refill", bus.outstanding_o, 4);
    chk("t4_refrdy", bus.req_ready_o, 0);
    chk("t4_pcdat", bus.pc_data_o, 128'hA5);

    // Reset with three words in flight
    man_mode = 1'b0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      req_val = 4'hF; #1;
      chk("t5_ready", bus.req_ready_o, 4'b0001 << c);
      step();
    end
    chk("t5_out3", bus.outstanding_o, 3);
    srst = 1'b1; #1;
    chk("t5_srst_rdy", bus.req_ready_o, 0);
    step();
    srst = 1'b0; req_val = '0;
    chk("t5_out0", bus.outstanding_o, 0);
    chk("t5_pcval", bus.pc_data_val_o, 0);
    chk("t5_pcdat", bus.pc_data_o, 0);
    chk("t5_resdat", bus.res_data_o, 0);
    for (int c = 0; c < 5; c++) begin
      chk("t5_nopulse", bus.res_val_o, 0);
      step();
    end
    req_val = 4'hF; #1;
    chk("t5_first", bus.req_ready_o, 4'b0001);

    // Orphan result with empty FIFO
    man_mode = 1'b1;
    do_reset();
    man_val = 1'b1; man_dat = 8'h05;
    step();
    man_val = 1'b0;
    chk("t6_err", bus.err_o, ERR_EN);
    chk("t6_resval", bus.res_val_o, 0);
    chk("t6_resdat", bus.res_data_o, 0);
    chk("t6_out", bus.outstanding_o, 0);
    step();
    chk("t6_err_hold", bus.err_o, ERR_EN);
    do_reset();
    chk("t6_err_clr", bus.err_o, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
